// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM transmitter.
//   NCH  : time slots per frame
//   SELW : slot-index width
//   tdm_state_e : transmitter FSM state encoding
package tdm_pkg;

  localparam int NCH  = 4;
  localparam int SELW = $clog2(NCH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    HOLD = 2'b10
  } tdm_state_e;

endpackage

// File: rtl/tdm_mux4_tx_if.sv
// Signal bundle between a TDM transmitter and its controller.
//   En, start, cont, din : controller -> transmitter
//   d, s, valid          : serialized slot toward the demux
//   busy, done           : frame status
// modport master: controller side; modport slave: transmitter side.
interface tdm_mux4_tx_if #(
  parameter int NCH  = tdm_pkg::NCH,
  parameter int SELW = tdm_pkg::SELW
);

  logic            En;
  logic            start;
  logic            cont;
  logic [NCH-1:0]  din;
  logic            d;
  logic [SELW-1:0] s;
  logic            valid;
  logic            busy;
  logic            done;

  modport master (
    output En, start, cont, din,
    input  d, s, valid, busy, done
  );

  modport slave (
    input  En, start, cont, din,
    output d, s, valid, busy, done
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM transmitter.
//   clk, rst : clock, async active-high reset
//   clr      : force count to 0 (has priority over inc)
//   inc      : advance by one slot; saturates at NCH-1 so a frame never wraps
//   cnt      : current slot index
//   last     : cnt is the final slot of the frame
module tdm_slot_counter #(
  parameter int NCH  = tdm_pkg::NCH,
  parameter int SELW = tdm_pkg::SELW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [SELW-1:0] cnt,
  output logic            last
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NCH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + SELW'(1);
    end
  end

  assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/tdm_mux4_tx.sv
// 4-slot TDM transmitter: latches din into a shadow register on a frame
// request and serializes it one slot per enabled cycle as (s, d, valid).
//   clk, rst : clock, async active-high reset
//   bus      : tdm_mux4_tx_if.slave (En, start, cont, din in;
//              d, s, valid, busy, done out)
//
// A slot is on the wire whenever the FSM is in SEND. An enabled edge while
// busy consumes the slot on the wire; a disabled edge parks in HOLD with the
// last-sent slot still shown (valid=0), and the next enabled edge moves on
// to the following slot, so nothing is skipped or repeated. done marks the
// cycle the final slot is on the wire, which keeps it inside busy.
module tdm_mux4_tx #(
  parameter int NCH  = tdm_pkg::NCH,
  parameter int SELW = tdm_pkg::SELW
) (
  input  logic         clk,
  input  logic         rst,
  tdm_mux4_tx_if.slave bus
);

  import tdm_pkg::*;

  tdm_state_e      state_q;
  tdm_state_e      state_d;
  logic [NCH-1:0]  shadow_q;
  logic            load;
  logic            cnt_clr;
  logic            cnt_inc;
  logic [SELW-1:0] cnt;
  logic            last;
  logic            active;

  tdm_slot_counter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_slot_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        shadow_q <= bus.din;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.En) begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_d = SEND;
        end
      end
      SEND, HOLD: begin
        if (!bus.En) begin
          state_d = HOLD;
        end else if (!last) begin
          cnt_inc = 1'b1;
          state_d = SEND;
        end else if (bus.cont) begin
          // back-to-back frame: reload without a gap cycle
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_d = SEND;
        end else begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign active    = (state_q == SEND) || (state_q == HOLD);
  assign bus.busy  = active;
  assign bus.valid = (state_q == SEND);
  assign bus.s     = active ? cnt : '0;
  assign bus.d     = active & shadow_q[cnt];
  assign bus.done  = (state_q == SEND) && last;

endmodule

// File: tb/tb_tdm_mux4_tx.sv
module tb_tdm_mux4_tx;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tdm_mux4_tx_if #(.NCH(4), .SELW(2)) bus();

  tdm_mux4_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is four slots; each enabled edge while a frame is open consumes
  // the slot on the wire. A slot is visible after an enabled edge (or the
  // accepting edge) and hidden after a disabled one.
  typedef struct {
    logic [1:0] s;
    logic       d;
    logic       done;
    logic [3:0] frame;
  } slot_t;

  slot_t sb_q[$];
  bit    m_active  = 1'b0;
  int    m_rem     = 0;
  bit    exp_valid = 1'b0;

  function automatic void accept(input logic [3:0] fr);
    slot_t e;
    for (int i = 0; i < NCH; i++) begin
      e.s     = 2'(i);
      e.d     = fr[i];
      e.done  = (i == NCH - 1);
      e.frame = fr;
      sb_q.push_back(e);
    end
    m_active  = 1'b1;
    m_rem     = NCH;
    exp_valid = 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
      m_active  = 1'b0;
      m_rem     = 0;
      exp_valid = 1'b0;
    end else if (!m_active) begin
      if (bus.start && bus.En) accept(bus.din);
      else exp_valid = 1'b0;
    end else if (bus.En) begin
      m_rem--;
      if (m_rem == 0) begin
        if (bus.cont) accept(bus.din);
        else begin
          m_active  = 1'b0;
          exp_valid = 1'b0;
        end
      end else begin
        exp_valid = 1'b1;
      end
    end else begin
      exp_valid = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  slot_t      mon_e;
  logic [1:0] last_s = '0;
  logic       last_d = 1'b0;
  logic [3:0] demux_out;

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", bus.valid, exp_valid);
      chk("busy", bus.busy, m_active);
      if (bus.valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          mon_e = sb_q.pop_front();
          chk("slot_s", bus.s, mon_e.s);
          chk("slot_d", bus.d, mon_e.d);
          chk("slot_done", bus.done, mon_e.done);
          demux_out = '0;
          demux_out[bus.s] = bus.d;
          chk("demux_loop", demux_out[bus.s], mon_e.frame[bus.s]);
          last_s = mon_e.s;
          last_d = mon_e.d;
        end
      end else begin
        chk("done_idle", bus.done, 0);
        if (bus.busy) begin
          chk("hold_s", bus.s, last_s);
          chk("hold_d", bus.d, last_d);
        end else begin
          chk("idle_s", bus.s, 0);
          chk("idle_d", bus.d, 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.busy && k < 60) begin
      tick();
      k++;
    end
    chk({name, "_idle"}, bus.busy, 0);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_d"}, bus.d, 0);
    chk({name, "_s"}, bus.s, 0);
    chk({name, "_valid"}, bus.valid, 0);
    chk({name, "_busy"}, bus.busy, 0);
    chk({name, "_done"}, bus.done, 0);
  endtask

  initial begin
    int k;
    bus.En = 1'b0;
    bus.start = 1'b0;
    bus.cont = 1'b0;
    bus.din = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // single frame, din=1011
    bus.din = 4'b1011; bus.En = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle("frame1011");
    chk("frame1011_drain", sb_q.size(), 0);

    // start ignored while disabled
    bus.En = 1'b0; bus.start = 1'b1; bus.din = 4'b0101;
    repeat (3) tick();
    bus.start = 1'b0;
    chk("en_low_busy", bus.busy, 0);

    // pause after slot 1, din=0110
    bus.din = 4'b0110; bus.En = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.En = 1'b0;
    tick();
    chk("pause_valid", bus.valid, 0);
    chk("pause_s", bus.s, 1);
    tick();
    bus.En = 1'b1;
    wait_idle("pause");

    // continuous mode, din changes mid-frame
    bus.din = 4'b1111; bus.cont = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.din = 4'b0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.cont = 1'b0;
    wait_idle("cont");

    // async reset at slot 2
    bus.din = 4'b1010; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.valid && bus.s == 2'd2) && k < 20);
    chk("rst_slot2_seen", bus.valid && bus.s == 2'd2, 1);
    #1 rst = 1'b1;
    #1 chk_zero_outputs("rst_mid");
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("rst_needs_start", bus.busy, 0);
    bus.din = 4'b1100; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle("restart");

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.En    = ($urandom_range(7) != 0);
      bus.start = ($urandom_range(3) == 0);
      bus.cont  = ($urandom_range(5) == 0);
      bus.din   = 4'($urandom);
      if ($urandom_range(249) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    bus.start = 1'b0; bus.cont = 1'b0; bus.En = 1'b1;
    wait_idle("random");
    tick();
    chk("final_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
